// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encodings, frame constants and divisor clamp for the 8N1 UART
package uart_pkg;

    localparam int          FRAME_DATA_BITS = 8;
    localparam logic [15:0] MIN_BAUD_DIV    = 16'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Divisors below two cannot express a bit centre, so they are raised to two.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d < MIN_BAUD_DIV) ? MIN_BAUD_DIV : d;
    endfunction

endpackage

// File: rtl/uart_if.sv
// rtl/uart_if.sv - parallel handshake and serial line bundle between a host and the UART
interface uart_if;
    logic [15:0] baud_div;
    logic        rx_in;
    logic        tx_out;
    logic        rx_latch;
    logic [7:0]  rx_data;
    logic        tx_latch;
    logic [7:0]  tx_data;
    logic        tx_empty;

    modport slave (
        input  baud_div, rx_in, tx_latch, tx_data,
        output tx_out, rx_latch, rx_data, tx_empty
    );

    modport master (
        output baud_div, rx_in, tx_latch, tx_data,
        input  tx_out, rx_latch, rx_data, tx_empty
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - rx_in synchronizer, start-edge detector and centre-sampling RX FSM
// UART_FRAMING_CHECK_EN: when defined, a frame whose stop bit samples low is discarded.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] baud_div,
    input  logic        rx_in,
    output logic        rx_latch,
    output logic [7:0]  rx_data
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic                   rx_prev;
    logic [1:0]             state;
    logic [15:0]            cnt;
    logic [15:0]            div;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;

    assign rx_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync     <= '1;
            rx_prev  <= 1'b1;
            state    <= ST_IDLE;
            cnt      <= 16'd0;
            div      <= MIN_BAUD_DIV;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
            rx_latch <= 1'b0;
            rx_data  <= 8'h00;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], rx_in};
            rx_prev  <= rx_s;
            rx_latch <= 1'b0;
            case (state)
                // An edge (not a level) arms the receiver, so a low line after a bad stop bit waits for high.
                ST_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state <= ST_START;
                        cnt   <= 16'd0;
                        div   <= eff_div(baud_div);
                    end
                end
                ST_START: begin
                    if (cnt == (div >> 1) - 16'd1) begin
                        cnt     <= 16'd0;
                        bit_idx <= 3'd0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt == div - 16'd1) begin
                        cnt   <= 16'd0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'(FRAME_DATA_BITS - 1)) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (cnt == div - 16'd1) begin
                        cnt   <= 16'd0;
                        state <= ST_IDLE;
`ifdef UART_FRAMING_CHECK_EN
                        if (rx_s) begin
                            rx_data  <= shreg;
                            rx_latch <= 1'b1;
                        end
`else
                        rx_data  <= shreg;
                        rx_latch <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart.sv
// rtl/uart.sv - full-duplex 8N1 UART top: TX FSM and shifter here, receiver in uart_rx
// UART_FRAMING_CHECK_EN: enables stop-bit framing-error discard in the receiver.
module uart
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic    clk,
    input  logic    reset,
    uart_if.slave   bus
);

    logic [1:0]  tx_state;
    logic [15:0] tx_cnt;
    logic [15:0] tx_div;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shreg;
    logic        tx_line;
    logic        rx_latch;
    logic [7:0]  rx_data;

    assign bus.tx_out   = tx_line;
    assign bus.tx_empty = (tx_state == ST_IDLE);
    assign bus.rx_latch = rx_latch;
    assign bus.rx_data  = rx_data;

    // The final cycle of every stop bit is spent in IDLE, so an accepted byte starts with no gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= 16'd0;
            tx_div   <= MIN_BAUD_DIV;
            tx_bit   <= 3'd0;
            tx_shreg <= 8'h00;
            tx_line  <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (bus.tx_latch) begin
                        tx_shreg <= bus.tx_data;
                        tx_div   <= eff_div(bus.baud_div);
                        tx_cnt   <= 16'd0;
                        tx_line  <= 1'b0;
                        tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt == tx_div - 16'd1) begin
                        tx_cnt   <= 16'd0;
                        tx_bit   <= 3'd0;
                        tx_line  <= tx_shreg[0];
                        tx_shreg <= {1'b0, tx_shreg[7:1]};
                        tx_state <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == tx_div - 16'd1) begin
                        tx_cnt <= 16'd0;
                        if (tx_bit == 3'(FRAME_DATA_BITS - 1)) begin
                            tx_line  <= 1'b1;
                            tx_state <= ST_STOP;
                        end else begin
                            tx_line  <= tx_shreg[0];
                            tx_shreg <= {1'b0, tx_shreg[7:1]};
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == tx_div - 16'd2) begin
                        tx_cnt   <= 16'd0;
                        tx_state <= ST_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    uart_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .baud_div (bus.baud_div),
        .rx_in    (bus.rx_in),
        .rx_latch (rx_latch),
        .rx_data  (rx_data)
    );

endmodule

// File: tb/tb_uart.sv
// tb/tb_uart.sv - self-checking bench for uart: vector table, loopback streams, direct RX drive, reset abort
module tb_uart;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic loopback = 1'b1;
    logic rx_drv = 1'b1;

    always #5 clk = ~clk;

    uart_if u();

    assign u.rx_in = loopback ? u.tx_out : rx_drv;

    uart #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] s_data [3];
    logic [9:0] s_line [3];
    logic [7:0] exp_q [$];
    logic [7:0] last_rx = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         rx_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each rx_latch pulse must match the oldest byte still owed.
    initial begin
        forever begin
            @(negedge clk);
            if (u.rx_latch === 1'b1) begin
                rx_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got rx_data %02h, expected no latch at %0t", u.rx_data, $time);
                end else begin
                    check("rx_byte", {24'd0, u.rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [7:0] d);
        exp_q.push_back(d);
        last_rx = d;
    endtask

    // Sends n frames back to back from s_data/s_line; optionally pokes tx_latch/baud_div mid-frame.
    task automatic run_frames(input string tag, input int n, input int poke_at);
        int         nxt;
        logic [9:0] ln;
        @(negedge clk);
        u.tx_latch = 1'b1;
        u.tx_data  = s_data[0];
        push_exp(s_data[0]);
        nxt = 1;
        for (int k = 0; k < n * 100; k++) begin
            @(negedge clk);
            u.tx_latch = 1'b0;
            ln = s_line[k / 100];
            check({tag, "_tx_out"}, {31'd0, u.tx_out}, {31'd0, ln[(k % 100) / 10]});
            check({tag, "_tx_empty"}, {31'd0, u.tx_empty}, {31'd0, ((k % 100) == 99)});
            if (k == poke_at) begin
                u.tx_latch = 1'b1;
                u.tx_data  = 8'hFF;
                u.baud_div = 16'd3;
            end
            if ((k % 100) == 99 && nxt < n) begin
                u.tx_latch = 1'b1;
                u.tx_data  = s_data[nxt];
                push_exp(s_data[nxt]);
                nxt++;
            end
        end
        u.baud_div = 16'd10;
        repeat (20) @(negedge clk);
        check({tag, "_rx_drained"}, exp_q.size(), 0);
        check({tag, "_rx_data"}, {24'd0, u.rx_data}, {24'd0, last_rx});
    endtask

    task automatic drive_rx_frame(input logic [7:0] d, input logic stop_bit);
        for (int j = 0; j < 10; j++) begin
            if (j == 0)      rx_drv = 1'b0;
            else if (j == 9) rx_drv = stop_bit;
            else             rx_drv = d[j - 1];
            repeat (10) @(negedge clk);
        end
    endtask

    initial begin
        int   base;
        logic low_seen;

        u.tx_latch = 1'b0;
        u.tx_data  = 8'h00;
        u.baud_div = 16'd10;

        vecs[0] = '{8'h56, 10'h2AC};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'hA5, 10'h34A};
        vecs[4] = '{8'h01, 10'h202};
        vecs[5] = '{8'h80, 10'h300};

        // Reset state and quiet idle line.
        repeat (3) @(negedge clk);
        check("rst_tx_out", {31'd0, u.tx_out}, 1);
        check("rst_tx_empty", {31'd0, u.tx_empty}, 1);
        check("rst_rx_latch", {31'd0, u.rx_latch}, 0);
        check("rst_rx_data", {24'd0, u.rx_data}, 0);
        reset = 1'b1;
        low_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (u.tx_out !== 1'b1 || u.tx_empty !== 1'b1) low_seen = 1'b1;
        end
        check("idle_tx_quiet", {31'd0, low_seen}, 0);
        check("idle_rx_count", rx_count, 0);

        // Single-frame vector table over loopback.
        for (int i = 0; i < 6; i++) begin
            s_data[0] = vecs[i].data;
            s_line[0] = vecs[i].line;
            run_frames("vec", 1, -1);
        end

        // Back-to-back stream, accepted on each tx_empty rise.
        s_data[0] = 8'h56; s_line[0] = 10'h2AC;
        s_data[1] = 8'h00; s_line[1] = 10'h200;
        s_data[2] = 8'h00; s_line[2] = 10'h200;
        run_frames("b2b", 3, -1);

        // tx_latch, tx_data and baud_div disturbed mid-frame.
        s_data[0] = 8'h56; s_line[0] = 10'h2AC;
        run_frames("busy", 1, 45);

        // Direct RX drive: glitch, bad stop bit, then a clean frame.
        loopback = 1'b0;
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        base = rx_count;
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (50) @(negedge clk);
        check("glitch_no_latch", rx_count - base, 0);

        base = rx_count;
`ifdef UART_FRAMING_CHECK_EN
        drive_rx_frame(8'hA5, 1'b0);
        repeat (10) @(negedge clk);
        check("frame_err_count", rx_count - base, 0);
`else
        push_exp(8'hA5);
        drive_rx_frame(8'hA5, 1'b0);
        repeat (10) @(negedge clk);
        check("frame_err_count", rx_count - base, 1);
`endif
        check("frame_err_rx_data", {24'd0, u.rx_data}, {24'd0, last_rx});
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        push_exp(8'h3C);
        drive_rx_frame(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        check("rearm_drained", exp_q.size(), 0);
        check("rearm_rx_data", {24'd0, u.rx_data}, 24'h3C);

        // Reset during data bit 4 of a looped-back frame.
        loopback = 1'b1;
        repeat (20) @(negedge clk);
        base = rx_count;
        u.tx_latch = 1'b1;
        u.tx_data  = 8'hC3;
        @(negedge clk);
        u.tx_latch = 1'b0;
        repeat (54) @(negedge clk);
        check("pre_abort_tx_empty", {31'd0, u.tx_empty}, 0);
        reset = 1'b0;
        #1;
        check("abort_tx_out", {31'd0, u.tx_out}, 1);
        check("abort_tx_empty", {31'd0, u.tx_empty}, 1);
        check("abort_rx_latch", {31'd0, u.rx_latch}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (150) @(negedge clk);
        check("abort_no_latch", rx_count - base, 0);
        check("abort_rx_data", {24'd0, u.rx_data}, 0);
        check("abort_tx_idle", {31'd0, u.tx_out}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
